// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDR SDRAM command responder with CL read pipeline and protocol checks
//
// Ports:
//   iclk, ireset            clock, synchronous active-low reset
//   DRAM_CKE                clock enable; low freezes the command path and read pipeline
//   DRAM_CLK                unused, pin compatibility only
//   DRAM_CS_N..DRAM_WE_N    command pins
//   DRAM_BA, DRAM_ADDR      bank and row/column/mode address (A10 = precharge flag)
//   DRAM_LDQM, DRAM_UDQM    write byte masks, high blocks the byte
//   dq_write                write data in
//   dq_read, odq_valid      read data out and its valid strobe
//   oerror, oerr_code       sticky violation flag and code of the first violation
//   orefresh_cnt            AUTO REFRESH counter
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int T_RCD    = 2
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CLK,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic [15:0] dq_write,
    output logic [15:0] dq_read,
    output logic        odq_valid,
    output logic        oerror,
    output logic [2:0]  oerr_code,
    output logic [15:0] orefresh_cnt
);

    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam logic [7:0] RCD_SAT = 8'(T_RCD);

    typedef enum logic {ST_UNINIT, ST_READY} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 bank_open_q, bank_open_d;
    logic [3:0][ROW_BITS-1:0]   bank_row_q, bank_row_d;
    logic [3:0][7:0]            rcd_cnt_q, rcd_cnt_d;
    logic                       cl3_q, cl3_d;
    logic [1:0]                 pipe_vld_q, pipe_vld_d;
    logic [1:0][15:0]           pipe_data_q, pipe_data_d;
    logic [15:0]                dq_read_q, dq_read_d;
    logic                       odq_valid_q, odq_valid_d;
    logic                       err_q, err_d;
    logic [2:0]                 err_code_q, err_code_d;
    logic [15:0]                ref_cnt_q, ref_cnt_d;

    logic [15:0] mem [0:DEPTH-1];

    logic unused_pins;
    assign unused_pins = ^{DRAM_CLK, DRAM_ADDR};

    // Command decode; CKE low turns every command into a NOP.
    logic [3:0] cmd_bits;
    logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_rw;
    assign cmd_bits = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    assign cmd_act  = DRAM_CKE && (cmd_bits == 4'b0011);
    assign cmd_rd   = DRAM_CKE && (cmd_bits == 4'b0101);
    assign cmd_wr   = DRAM_CKE && (cmd_bits == 4'b0100);
    assign cmd_pre  = DRAM_CKE && (cmd_bits == 4'b0010);
    assign cmd_ref  = DRAM_CKE && (cmd_bits == 4'b0001);
    assign cmd_lmr  = DRAM_CKE && (cmd_bits == 4'b0000);
    assign cmd_rw   = cmd_rd || cmd_wr;

    logic          bank_is_open;
    logic          mode_ok;
    logic [AW-1:0] acc_addr;
    logic [15:0]   rd_data;
    assign bank_is_open = bank_open_q[DRAM_BA];
    assign mode_ok  = ((DRAM_ADDR[6:4] == 3'd2) || (DRAM_ADDR[6:4] == 3'd3)) && (DRAM_ADDR[2:0] == 3'b000);
    assign acc_addr = {DRAM_BA, bank_row_q[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
    assign rd_data  = mem[acc_addr];

    // Violation classification; a nonzero code cancels the command entirely.
    logic [2:0] err_new;
    always_comb begin
        err_new = 3'd0;
        if (cmd_rw) begin
            if (state_q == ST_UNINIT)                err_new = 3'd1;
            else if (!bank_is_open)                  err_new = 3'd2;
            else if (rcd_cnt_q[DRAM_BA] < RCD_SAT)   err_new = 3'd4;
        end else if (cmd_act && bank_is_open) begin
            err_new = 3'd3;
        end else if ((cmd_ref || cmd_lmr) && (|bank_open_q)) begin
            err_new = 3'd5;
        end else if (cmd_lmr && !mode_ok) begin
            err_new = 3'd6;
        end
    end

    logic cmd_ok, act_ok, rd_ok, wr_ok, lmr_ok, ref_ok;
    assign cmd_ok = (err_new == 3'd0);
    assign act_ok = cmd_act && cmd_ok;
    assign rd_ok  = cmd_rd  && cmd_ok;
    assign wr_ok  = cmd_wr  && cmd_ok;
    assign lmr_ok = cmd_lmr && cmd_ok;
    assign ref_ok = cmd_ref && cmd_ok;

    // Global init state: next-state logic
    always_comb begin
        state_d = state_q;
        if (lmr_ok) state_d = ST_READY;
    end

    // Bank tracking, mode, read pipeline, error and refresh bookkeeping
    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        rcd_cnt_d   = rcd_cnt_q;
        cl3_d       = cl3_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_data_d = pipe_data_q;
        dq_read_d   = dq_read_q;
        odq_valid_d = odq_valid_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        ref_cnt_d   = ref_cnt_q;

        if (DRAM_CKE) begin
            for (int b = 0; b < 4; b++) begin
                if (rcd_cnt_q[b] < RCD_SAT) rcd_cnt_d[b] = rcd_cnt_q[b] + 8'd1;
            end

            // Data is captured when the READ is accepted, so a later WRITE
            // cannot alter a read already in flight. Stage 0 feeds the output
            // for CL2, stage 1 for CL3.
            pipe_vld_d[1]  = pipe_vld_q[0];
            pipe_data_d[1] = pipe_data_q[0];
            pipe_vld_d[0]  = rd_ok;
            pipe_data_d[0] = rd_data;

            odq_valid_d = cl3_q ? pipe_vld_q[1] : pipe_vld_q[0];
            if (odq_valid_d) dq_read_d = cl3_q ? pipe_data_q[1] : pipe_data_q[0];
        end

        if (act_ok) begin
            bank_open_d[DRAM_BA] = 1'b1;
            bank_row_d[DRAM_BA]  = DRAM_ADDR[ROW_BITS-1:0];
            // Loaded with 1 so the count equals elapsed edges when the next command is sampled.
            rcd_cnt_d[DRAM_BA]   = 8'd1;
        end
        if ((rd_ok || wr_ok) && DRAM_ADDR[10]) bank_open_d[DRAM_BA] = 1'b0;
        if (cmd_pre) begin
            if (DRAM_ADDR[10]) bank_open_d = 4'b0000;
            else               bank_open_d[DRAM_BA] = 1'b0;
        end
        if (lmr_ok) cl3_d = (DRAM_ADDR[6:4] == 3'd3);
        if (ref_ok) ref_cnt_d = ref_cnt_q + 16'd1;

        if (!cmd_ok && !err_q) begin
            err_d      = 1'b1;
            err_code_d = err_new;
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state_q     <= ST_UNINIT;
            bank_open_q <= 4'b0000;
            bank_row_q  <= '0;
            rcd_cnt_q   <= '0;
            cl3_q       <= 1'b0;
            pipe_vld_q  <= 2'b00;
            pipe_data_q <= '0;
            dq_read_q   <= 16'h0000;
            odq_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            ref_cnt_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            rcd_cnt_q   <= rcd_cnt_d;
            cl3_q       <= cl3_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            dq_read_q   <= dq_read_d;
            odq_valid_q <= odq_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            ref_cnt_q   <= ref_cnt_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge iclk) begin
        if (ireset && wr_ok) begin
            if (!DRAM_LDQM) mem[acc_addr][7:0]  <= dq_write[7:0];
            if (!DRAM_UDQM) mem[acc_addr][15:8] <= dq_write[15:8];
        end
    end

    // Outputs
    assign dq_read      = dq_read_q;
    assign odq_valid    = odq_valid_q;
    assign oerror       = err_q;
    assign oerr_code    = err_code_q;
    assign orefresh_cnt = ref_cnt_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed self-checking bench for sdram_responder
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        iclk;
    logic        ireset;
    logic        DRAM_CKE;
    logic        DRAM_CLK;
    logic        DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic [1:0]  DRAM_BA;
    logic [12:0] DRAM_ADDR;
    logic        DRAM_LDQM, DRAM_UDQM;
    logic [15:0] dq_write;
    logic [15:0] dq_read;
    logic        odq_valid;
    logic        oerror;
    logic [2:0]  oerr_code;
    logic [15:0] orefresh_cnt;

    int asserts  = 0;
    int failures = 0;

    sdram_responder #(.ROW_BITS(4), .COL_BITS(4), .T_RCD(2)) dut (
        .iclk(iclk), .ireset(ireset), .DRAM_CKE(DRAM_CKE), .DRAM_CLK(DRAM_CLK),
        .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N),
        .DRAM_BA(DRAM_BA), .DRAM_ADDR(DRAM_ADDR), .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM),
        .dq_write(dq_write), .dq_read(dq_read), .odq_valid(odq_valid), .oerror(oerror),
        .oerr_code(oerr_code), .orefresh_cnt(orefresh_cnt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;
    assign DRAM_CLK = iclk;

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] c);
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
        set_cmd(c);
        DRAM_BA = ba;
        DRAM_ADDR = addr;
        tick;
        set_cmd(C_NOP);
    endtask

    task automatic nop;
        issue(C_NOP, 2'd0, 13'h0);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [3:0] col, input logic [15:0] d,
                      input logic lm, input logic um);
        dq_write = d;
        DRAM_LDQM = lm;
        DRAM_UDQM = um;
        issue(C_WR, ba, {9'd0, col});
        DRAM_LDQM = 1'b0;
        DRAM_UDQM = 1'b0;
    endtask

    task automatic apply_reset;
        ireset = 1'b0;
        DRAM_CKE = 1'b1;
        set_cmd(C_NOP);
        tick;
        ireset = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        asserts++; if (dq_read !== 16'h0000) begin failures++; $display("FAIL reset_dq: got %h want 0000", dq_read); end
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", odq_valid); end
        asserts++; if (oerror !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", oerror); end
        asserts++; if (oerr_code !== 3'd0) begin failures++; $display("FAIL reset_code: got %0d want 0", oerr_code); end
        asserts++; if (orefresh_cnt !== 16'h0) begin failures++; $display("FAIL reset_refcnt: got %0d want 0", orefresh_cnt); end
    endtask

    task automatic test_init_access;
        issue(C_LMR, 2'd0, 13'h020);
        issue(C_ACT, 2'd0, 13'd3);
        nop;
        wr(2'd0, 4'd5, 16'h0013, 1'b0, 1'b0);
        issue(C_RD, 2'd0, 13'd5);
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cl2_early: valid got %b want 0", odq_valid); end
        nop;
        asserts++; if (odq_valid !== 1'b1) begin failures++; $display("FAIL cl2_valid: got %b want 1", odq_valid); end
        asserts++; if (dq_read !== 16'h0013) begin failures++; $display("FAIL cl2_data: got %h want 0013", dq_read); end
        nop;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cl2_pulse: valid got %b want 0", odq_valid); end
        asserts++; if (dq_read !== 16'h0013) begin failures++; $display("FAIL cl2_hold: got %h want 0013", dq_read); end
        asserts++; if (oerror !== 1'b0) begin failures++; $display("FAIL init_noerr: got %b want 0", oerror); end
    endtask

    task automatic test_cl3_back_to_back;
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_LMR, 2'd0, 13'h030);
        issue(C_ACT, 2'd0, 13'd3);
        nop;
        wr(2'd0, 4'd1, 16'hAAAA, 1'b0, 1'b0);
        wr(2'd0, 4'd2, 16'h5555, 1'b0, 1'b0);
        issue(C_RD, 2'd0, 13'd1);
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cl3_n0: valid got %b want 0", odq_valid); end
        issue(C_RD, 2'd0, 13'd2);
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cl3_n1: valid got %b want 0", odq_valid); end
        nop;
        asserts++; if (odq_valid !== 1'b1 || dq_read !== 16'hAAAA) begin failures++; $display("FAIL cl3_first: valid %b data %h want 1 AAAA", odq_valid, dq_read); end
        nop;
        asserts++; if (odq_valid !== 1'b1 || dq_read !== 16'h5555) begin failures++; $display("FAIL cl3_second: valid %b data %h want 1 5555", odq_valid, dq_read); end
        nop;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cl3_end: valid got %b want 0", odq_valid); end
    endtask

    task automatic test_byte_mask;
        wr(2'd0, 4'd7, 16'hFFFF, 1'b0, 1'b0);
        wr(2'd0, 4'd7, 16'h1234, 1'b0, 1'b1);
        issue(C_RD, 2'd0, 13'd7);
        nop;
        nop;
        asserts++; if (odq_valid !== 1'b1 || dq_read !== 16'hFF34) begin failures++; $display("FAIL udqm: valid %b data %h want 1 FF34", odq_valid, dq_read); end
        wr(2'd0, 4'd7, 16'hABCD, 1'b1, 1'b0);
        asserts++; if (oerror !== 1'b0) begin failures++; $display("FAIL mask_noerr: got %b want 0", oerror); end
    endtask

    task automatic test_cke_freeze;
        // Location 7 now holds AB34 after the LDQM-masked write.
        issue(C_RD, 2'd0, 13'd7);
        DRAM_CKE = 1'b0;
        set_cmd(C_RD);
        DRAM_ADDR = 13'd1;
        tick;
        tick;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cke_frozen: valid got %b want 0", odq_valid); end
        DRAM_CKE = 1'b1;
        set_cmd(C_NOP);
        tick;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cke_early: valid got %b want 0", odq_valid); end
        tick;
        asserts++; if (odq_valid !== 1'b1 || dq_read !== 16'hAB34) begin failures++; $display("FAIL cke_data: valid %b data %h want 1 AB34", odq_valid, dq_read); end
        tick;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL cke_ignored_rd: valid got %b want 0", odq_valid); end
    endtask

    task automatic test_refresh;
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_ACT, 2'd0, 13'd3);
        issue(C_ACT, 2'd1, 13'd2);
        issue(C_PRE, 2'd0, 13'h400);
        for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 13'h0);
        asserts++; if (orefresh_cnt !== 16'd3) begin failures++; $display("FAIL ref_cnt: got %0d want 3", orefresh_cnt); end
        asserts++; if (oerror !== 1'b0) begin failures++; $display("FAIL ref_noerr: got %b want 0", oerror); end
        issue(C_ACT, 2'd2, 13'd0);
        issue(C_REF, 2'd0, 13'h0);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd5) begin failures++; $display("FAIL ref_open: err %b code %0d want 1 5", oerror, oerr_code); end
        asserts++; if (orefresh_cnt !== 16'd3) begin failures++; $display("FAIL ref_blocked: got %0d want 3", orefresh_cnt); end
    endtask

    task automatic test_violations;
        apply_reset;
        issue(C_RD, 2'd0, 13'd0);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd1) begin failures++; $display("FAIL err_uninit: err %b code %0d want 1 1", oerror, oerr_code); end

        apply_reset;
        issue(C_LMR, 2'd0, 13'h020);
        issue(C_RD, 2'd1, 13'd0);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd2) begin failures++; $display("FAIL err_idle: err %b code %0d want 1 2", oerror, oerr_code); end
        issue(C_ACT, 2'd1, 13'd1);
        issue(C_RD, 2'd1, 13'd0);
        asserts++; if (oerr_code !== 3'd2) begin failures++; $display("FAIL err_first_wins: code %0d want 2", oerr_code); end
        for (int i = 0; i < 3; i++) begin
            nop;
            asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL err_no_read %0d: valid got %b want 0", i, odq_valid); end
        end

        apply_reset;
        issue(C_LMR, 2'd0, 13'h040);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd6) begin failures++; $display("FAIL err_mode: err %b code %0d want 1 6", oerror, oerr_code); end

        apply_reset;
        issue(C_LMR, 2'd0, 13'h020);
        issue(C_ACT, 2'd0, 13'd3);
        issue(C_ACT, 2'd0, 13'd4);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd3) begin failures++; $display("FAIL err_act_open: err %b code %0d want 1 3", oerror, oerr_code); end

        apply_reset;
        issue(C_LMR, 2'd0, 13'h020);
        issue(C_ACT, 2'd0, 13'd3);
        issue(C_RD, 2'd0, 13'd5);
        asserts++; if (oerror !== 1'b1 || oerr_code !== 3'd4) begin failures++; $display("FAIL err_trcd: err %b code %0d want 1 4", oerror, oerr_code); end
        nop;
        asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL err_trcd_read: valid got %b want 0", odq_valid); end
    endtask

    task automatic test_reset_mid_read;
        apply_reset;
        issue(C_LMR, 2'd0, 13'h030);
        issue(C_ACT, 2'd0, 13'd3);
        nop;
        issue(C_RD, 2'd0, 13'd5);
        nop;
        nop;
        asserts++; if (odq_valid !== 1'b1 || dq_read !== 16'h0013) begin failures++; $display("FAIL pre_reset_read: valid %b data %h want 1 0013", odq_valid, dq_read); end
        issue(C_RD, 2'd0, 13'd5);
        ireset = 1'b0;
        tick;
        ireset = 1'b1;
        asserts++; if (odq_valid !== 1'b0 || dq_read !== 16'h0000) begin failures++; $display("FAIL mid_reset_out: valid %b data %h want 0 0000", odq_valid, dq_read); end
        asserts++; if (oerror !== 1'b0 || oerr_code !== 3'd0 || orefresh_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_state: err %b code %0d ref %0d want 0 0 0", oerror, oerr_code, orefresh_cnt); end
        for (int i = 0; i < 3; i++) begin
            nop;
            asserts++; if (odq_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_flush %0d: valid got %b want 0", i, odq_valid); end
        end
    endtask

    initial begin
        ireset = 1'b0;
        DRAM_CKE = 1'b1;
        set_cmd(C_NOP);
        DRAM_BA = 2'd0;
        DRAM_ADDR = 13'h0;
        DRAM_LDQM = 1'b0;
        DRAM_UDQM = 1'b0;
        dq_write = 16'h0;

        test_reset;
        test_init_access;
        test_cl3_back_to_back;
        test_byte_mask;
        test_cke_freeze;
        test_refresh;
        test_violations;
        test_reset_mid_read;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
